// File: rtl/fetch_unit.sv
// Instruction fetch stage for the bf8b core: assembles 16-bit words from two
// byte reads (high byte first), holds them for decode and tracks the PC.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no fetch in progress; waits here while halt is asserted
// FETCH_HI | reading high byte at pc, waiting for mem_ready
// FETCH_LO | reading low byte at pc+1, waiting for mem_ready
// HOLD     | word presented on inst with inst_valid=1 until inst_ack
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   input  logic        mem_ready,
   output logic [15:0] inst,
   output logic        inst_valid,
   input  logic        inst_ack,
   input  logic        jmp_en,
   input  logic [7:0]  jmp_addr,
   input  logic        halt,
   output logic        halted,
   output logic [7:0]  pc
);

   localparam logic [7:0] PC_INIT = {RESET_PC[7:1], 1'b0};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH_HI = 2'd1,
      FETCH_LO = 2'd2,
      HOLD     = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  pc_nxt;
   logic [7:0]  addr_nxt;
   logic        rd_nxt;
   logic [15:0] inst_nxt;
   logic        valid_nxt;
   logic        halted_nxt;
   logic [7:0]  jmp_target;

   assign jmp_target = {jmp_addr[7:1], 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= PC_INIT;
         mem_addr   <= 8'h00;
         mem_rd     <= 1'b0;
         inst       <= 16'h0000;
         inst_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         mem_addr   <= addr_nxt;
         mem_rd     <= rd_nxt;
         inst       <= inst_nxt;
         inst_valid <= valid_nxt;
         halted     <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      addr_nxt   = mem_addr;
      rd_nxt     = mem_rd;
      inst_nxt   = inst;
      valid_nxt  = inst_valid;
      halted_nxt = halted;

      // A jump overrides everything, including a read or ack landing this cycle.
      if (jmp_en) begin
         pc_nxt    = jmp_target;
         valid_nxt = 1'b0;
         if (halt) begin
            state_nxt = IDLE;
            rd_nxt    = 1'b0;
         end else begin
            state_nxt  = FETCH_HI;
            addr_nxt   = jmp_target;
            rd_nxt     = 1'b1;
            halted_nxt = 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (halt) begin
                  halted_nxt = 1'b1;
               end else begin
                  state_nxt  = FETCH_HI;
                  addr_nxt   = pc;
                  rd_nxt     = 1'b1;
                  halted_nxt = 1'b0;
               end
            end
            FETCH_HI: begin
               if (mem_ready) begin
                  inst_nxt[15:8] = mem_data;
                  addr_nxt       = pc + 8'd1;
                  state_nxt      = FETCH_LO;
               end
            end
            FETCH_LO: begin
               if (mem_ready) begin
                  inst_nxt[7:0] = mem_data;
                  valid_nxt     = 1'b1;
                  rd_nxt        = 1'b0;
                  pc_nxt        = pc + 8'd2;
                  state_nxt     = HOLD;
               end
            end
            HOLD: begin
               if (inst_ack) begin
                  valid_nxt = 1'b0;
                  if (halt) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = FETCH_HI;
                     addr_nxt  = pc;
                     rd_nxt    = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               rd_nxt    = 1'b0;
               valid_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: byte memory model with configurable wait
// states, hand-computed expectations at each step.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        mem_ready;
   logic [15:0] inst;
   logic        inst_valid;
   logic        inst_ack;
   logic        jmp_en;
   logic [7:0]  jmp_addr;
   logic        halt;
   logic        halted;
   logic [7:0]  pc;

   logic [7:0]  mem [256];
   int          wait_states;
   int          wcnt;
   logic [7:0]  last_addr;
   int          checks;
   int          failures;

   fetch_unit #(.RESET_PC(8'h00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_ready  (mem_ready),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ack   (inst_ack),
      .jmp_en     (jmp_en),
      .jmp_addr   (jmp_addr),
      .halt       (halt),
      .halted     (halted),
      .pc         (pc)
   );

   assign mem_data = mem[mem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: asserts mem_ready after wait_states idle cycles per address.
   initial begin
      mem_ready = 1'b0;
      wcnt      = 0;
      last_addr = 8'h00;
      forever begin
         @(negedge clk);
         if (!mem_rd || mem_addr != last_addr) wcnt = 0;
         last_addr = mem_addr;
         if (mem_rd && wcnt >= wait_states) begin
            mem_ready = 1'b1;
            wcnt      = 0;
         end else begin
            mem_ready = 1'b0;
            if (mem_rd) wcnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      wait_states = 0;
      rst_n       = 1'b0;
      inst_ack    = 1'b0;
      jmp_en      = 1'b0;
      jmp_addr    = 8'h00;
      halt        = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
      mem[8'h02] = 8'hAB; mem[8'h03] = 8'hCD;
      mem[8'h40] = 8'h77; mem[8'h41] = 8'h88;
      mem[8'hFE] = 8'h55; mem[8'hFF] = 8'h66;

      #12;
      chk("rst_pc", pc, 8'h00);
      chk("rst_inst", inst, 16'h0000);
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_rd", mem_rd, 1'b0);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_halted", halted, 1'b0);

      // Zero wait states: 3-cycle latency, back-to-back words
      @(negedge clk); rst_n = 1'b1;
      step(1);
      chk("f1_rd", mem_rd, 1'b1);
      chk("f1_addr_hi", mem_addr, 8'h00);
      step(1);
      chk("f1_addr_lo", mem_addr, 8'h01);
      chk("f1_novalid", inst_valid, 1'b0);
      step(1);
      chk("f1_inst", inst, 16'h1234);
      chk("f1_valid", inst_valid, 1'b1);
      chk("f1_pc", pc, 8'h02);
      chk("f1_rd_hold", mem_rd, 1'b0);
      inst_ack = 1'b1;
      step(1);
      inst_ack = 1'b0;
      chk("f2_valid_drop", inst_valid, 1'b0);
      chk("f2_addr_hi", mem_addr, 8'h02);
      chk("f2_rd", mem_rd, 1'b1);
      step(2);
      chk("f2_inst", inst, 16'hABCD);
      chk("f2_valid", inst_valid, 1'b1);
      chk("f2_pc", pc, 8'h04);
      inst_ack = 1'b1;
      step(1);
      inst_ack = 1'b0;
      chk("f3_addr", mem_addr, 8'h04);

      // Jump back to 0 in FETCH_HI, then two wait states per byte
      wait_states = 2;
      jmp_en = 1'b1; jmp_addr = 8'h00;
      step(1);
      jmp_en = 1'b0;
      chk("ws_pc", pc, 8'h00);
      chk("ws_addr0", mem_addr, 8'h00);
      for (int i = 1; i <= 5; i++) begin
         step(1);
         chk("ws_novalid", inst_valid, 1'b0);
         chk("ws_rd", mem_rd, 1'b1);
         chk("ws_addr", mem_addr, (i < 3) ? 8'h00 : 8'h01);
      end
      step(1);
      chk("ws_inst", inst, 16'h1234);
      chk("ws_valid", inst_valid, 1'b1);
      chk("ws_pc2", pc, 8'h02);

      // Ack withheld for 5 cycles
      wait_states = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("hold_inst", inst, 16'h1234);
         chk("hold_valid", inst_valid, 1'b1);
         chk("hold_rd", mem_rd, 1'b0);
         chk("hold_pc", pc, 8'h02);
      end
      inst_ack = 1'b1;
      step(1);
      inst_ack = 1'b0;
      chk("hold_next_addr", mem_addr, 8'h02);

      // Jump during FETCH_LO with mem_ready high: word discarded
      step(1);
      chk("jmp_in_lo_addr", mem_addr, 8'h03);
      jmp_en = 1'b1; jmp_addr = 8'h41;
      step(1);
      jmp_en = 1'b0;
      chk("jmp_pc", pc, 8'h40);
      chk("jmp_addr", mem_addr, 8'h40);
      chk("jmp_valid", inst_valid, 1'b0);
      chk("jmp_rd", mem_rd, 1'b1);
      step(1);
      chk("jmp_valid2", inst_valid, 1'b0);
      step(1);
      chk("jmp_inst", inst, 16'h7788);
      chk("jmp_pc2", pc, 8'h42);
      inst_ack = 1'b1;
      step(1);
      inst_ack = 1'b0;

      // PC wrap from FE
      jmp_en = 1'b1; jmp_addr = 8'hFE;
      step(1);
      jmp_en = 1'b0;
      chk("wrap_addr", mem_addr, 8'hFE);
      step(1);
      chk("wrap_addr_lo", mem_addr, 8'hFF);
      step(1);
      chk("wrap_inst", inst, 16'h5566);
      chk("wrap_pc", pc, 8'h00);
      inst_ack = 1'b1;
      step(1);
      inst_ack = 1'b0;

      // Halt raised during FETCH_HI: finish the word, then idle
      halt = 1'b1;
      step(2);
      chk("halt_inst", inst, 16'h1234);
      chk("halt_valid", inst_valid, 1'b1);
      chk("halt_halted0", halted, 1'b0);
      inst_ack = 1'b1;
      step(1);
      inst_ack = 1'b0;
      chk("halt_rd", mem_rd, 1'b0);
      chk("halt_valid0", inst_valid, 1'b0);
      step(1);
      chk("halt_halted", halted, 1'b1);
      step(2);
      chk("halt_rd_idle", mem_rd, 1'b0);
      chk("halt_pc", pc, 8'h02);
      halt = 1'b0;
      step(1);
      chk("resume_addr", mem_addr, 8'h02);
      chk("resume_rd", mem_rd, 1'b1);
      chk("resume_halted", halted, 1'b0);
      step(1);
      chk("pre_rst_addr", mem_addr, 8'h03);

      // Asynchronous reset in FETCH_LO
      rst_n = 1'b0;
      #1;
      chk("arst_pc", pc, 8'h00);
      chk("arst_inst", inst, 16'h0000);
      chk("arst_valid", inst_valid, 1'b0);
      chk("arst_rd", mem_rd, 1'b0);
      chk("arst_addr", mem_addr, 8'h00);
      chk("arst_halted", halted, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      step(3);
      chk("post_rst_inst", inst, 16'h1234);
      chk("post_rst_valid", inst_valid, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
